// File: rtl/logic_sweep_checker_if.sv
// Bus between the sweep checker and its surroundings: control/status toward the lab
// switches and LEDs, stimulus and sample lines toward the logic unit under check.
interface logic_sweep_checker_if #(
    parameter int ERR_W = 4
);
    // start is a level, accepted only while the checker is idle (busy=0); done
    // is a one-cycle completion pulse and the result fields stay valid until the
    // next accepted start. There is no backpressure in either direction.
    logic             start;
    logic             x_in;
    logic             y_in;
    logic             a_out;
    logic             b_out;
    logic             c_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [2:0]       first_fail_vec;
    logic             first_fail_valid;
    logic             fail_x;
    logic             fail_y;
    logic [1:0]       dbg_state;

    modport slave (
        input  start, x_in, y_in,
        output a_out, b_out, c_out, busy, done, pass, err_count,
               first_fail_vec, first_fail_valid, fail_x, fail_y, dbg_state
    );

    modport master (
        output start, x_in, y_in,
        input  a_out, b_out, c_out, busy, done, pass, err_count,
               first_fail_vec, first_fail_valid, fail_x, fail_y, dbg_state
    );
endinterface

// File: rtl/logic_sweep_checker.sv
// Walks all eight a/b/c vectors through the lab logic unit, samples x/y after a settle
// window and accumulates mismatch statistics against y=a&b, x=(a|b)^~c.
module logic_sweep_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    logic_sweep_checker_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    logic [1:0]       state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [2:0]       ffvec_q, ffvec_d;
    logic             ffvalid_q, ffvalid_d;
    logic             fx_q, fx_d;
    logic             fy_q, fy_d;
    logic             pass_q, pass_d;

    logic x_exp, y_exp, mis_x, mis_y;

    assign y_exp = vec_q[2] & vec_q[1];
    assign x_exp = (vec_q[2] | vec_q[1]) ^ ~vec_q[0];
    assign mis_x = bus.x_in != x_exp;
    assign mis_y = bus.y_in != y_exp;

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ffvec_d   = ffvec_q;
        ffvalid_d = ffvalid_q;
        fx_d      = fx_q;
        fy_d      = fy_q;
        pass_d    = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_SETTLE;
                    vec_d     = 3'd0;
                    cnt_d     = '0;
                    err_d     = '0;
                    ffvec_d   = 3'd0;
                    ffvalid_d = 1'b0;
                    fx_d      = 1'b0;
                    fy_d      = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (mis_x || mis_y) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!ffvalid_q) begin
                        ffvec_d   = vec_q;
                        ffvalid_d = 1'b1;
                    end
                end
                fx_d = fx_q | mis_x;
                fy_d = fy_q | mis_y;
                // The last vector ends the sweep without wrapping so a/b/c keep showing 7.
                if (vec_q != 3'd7) begin
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vec_q     <= 3'd0;
            cnt_q     <= '0;
            err_q     <= '0;
            ffvec_q   <= 3'd0;
            ffvalid_q <= 1'b0;
            fx_q      <= 1'b0;
            fy_q      <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ffvec_q   <= ffvec_d;
            ffvalid_q <= ffvalid_d;
            fx_q      <= fx_d;
            fy_q      <= fy_d;
            pass_q    <= pass_d;
        end
    end

    assign bus.a_out            = vec_q[2];
    assign bus.b_out            = vec_q[1];
    assign bus.c_out            = vec_q[0];
    assign bus.busy             = (state_q != ST_IDLE);
    assign bus.done             = (state_q == ST_DONE);
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_vec   = ffvec_q;
    assign bus.first_fail_valid = ffvalid_q;
    assign bus.fail_x           = fx_q;
    assign bus.fail_y           = fy_q;
    assign bus.dbg_state        = state_q;
endmodule

// File: tb/tb_logic_sweep_checker.sv
// Bench for logic_sweep_checker: two instances (settle 2 / 4-bit count, settle 1 / 2-bit count)
// share start and reset and each drive their own faulty copy of the lab logic unit.
module tb_logic_sweep_checker;
    localparam int NI = 2;

    function automatic int s_of(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    function automatic int w_of(input int g);
        return (g == 0) ? 4 : 2;
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [7:0] fx = 8'h00;
    logic [7:0] fy = 8'h00;
    logic noise_x = 1'b0;
    logic noise_y = 1'b0;

    logic [NI-1:0] o_a, o_b, o_c, o_busy, o_done, o_pass, o_ffv, o_fx, o_fy, chk_win;
    logic [7:0]    o_err   [NI];
    logic [2:0]    o_ffvec [NI];
    logic [1:0]    o_dbg   [NI];

    int         m_t   [NI];
    logic       m_act [NI];
    logic       m_run [NI];
    logic [7:0] m_fx  [NI];
    logic [7:0] m_fy  [NI];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int S = (g == 0) ? 2 : 1;
        localparam int W = (g == 0) ? 4 : 2;
        logic [2:0] v;

        logic_sweep_checker_if #(.ERR_W(W)) bus ();

        logic_sweep_checker #(.SETTLE_CYCLES(S), .ERR_W(W)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        // Unit under check: correct logic with per-vector fault flips; outside the
        // sample window its outputs are scrambled, which the checker must ignore.
        assign v          = {bus.a_out, bus.b_out, bus.c_out};
        assign bus.start  = start;
        assign bus.x_in   = ((v[2] | v[1]) ^ ~v[0]) ^ fx[v] ^ (noise_x & ~chk_win[g]);
        assign bus.y_in   = (v[2] & v[1]) ^ fy[v] ^ (noise_y & ~chk_win[g]);
        assign chk_win[g] = m_act[g] && (m_t[g] < 8 * (S + 1)) && (((m_t[g] + 1) % (S + 1)) == 0);

        assign o_a[g]     = bus.a_out;
        assign o_b[g]     = bus.b_out;
        assign o_c[g]     = bus.c_out;
        assign o_busy[g]  = bus.busy;
        assign o_done[g]  = bus.done;
        assign o_pass[g]  = bus.pass;
        assign o_ffv[g]   = bus.first_fail_valid;
        assign o_fx[g]    = bus.fail_x;
        assign o_fy[g]    = bus.fail_y;
        assign o_err[g]   = 8'(bus.err_count);
        assign o_ffvec[g] = bus.first_fail_vec;
        assign o_dbg[g]   = bus.dbg_state;
    end

    // Reference timeline: m_t counts edges since the accepting edge of the current sweep.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NI; g++) begin
                m_t[g]   <= 0;
                m_act[g] <= 1'b0;
                m_run[g] <= 1'b0;
                m_fx[g]  <= 8'h00;
                m_fy[g]  <= 8'h00;
            end
        end else begin
            for (int g = 0; g < NI; g++) begin
                if (!m_act[g]) begin
                    if (start) begin
                        m_act[g] <= 1'b1;
                        m_run[g] <= 1'b1;
                        m_t[g]   <= 0;
                        m_fx[g]  <= fx;
                        m_fy[g]  <= fy;
                    end
                end else begin
                    m_t[g] <= m_t[g] + 1;
                    if (m_t[g] + 1 == 8 * (s_of(g) + 1) + 1) m_act[g] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int g, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, g, act, exp, $time);
        end
    endtask

    task automatic compare_inst(input int g);
        int s_len, lim, per, nchk, nerr, maxe;
        int e_vec, e_err, e_ffvec;
        logic e_busy, e_done, e_pass, e_ffv, e_fx, e_fy;
        s_len = s_of(g) + 1;
        lim   = 8 * s_len;
        maxe  = (1 << w_of(g)) - 1;
        e_vec = 0; e_err = 0; e_ffvec = 0;
        e_busy = 0; e_done = 0; e_pass = 0; e_ffv = 0; e_fx = 0; e_fy = 0;
        if (m_run[g]) begin
            per    = m_t[g] / s_len;
            nchk   = (per > 8) ? 8 : per;
            e_vec  = (per > 7) ? 7 : per;
            e_busy = m_act[g];
            e_done = m_act[g] && (m_t[g] == lim);
            nerr   = 0;
            for (int v = 0; v < nchk; v++) begin
                if (m_fx[g][v] || m_fy[g][v]) begin
                    if (nerr == 0) e_ffvec = v;
                    nerr++;
                end
                e_fx = e_fx | m_fx[g][v];
                e_fy = e_fy | m_fy[g][v];
            end
            e_err  = (nerr > maxe) ? maxe : nerr;
            e_ffv  = (nerr > 0);
            e_pass = (m_t[g] >= lim) && (nerr == 0);
        end
        chk("vec", g, int'({o_a[g], o_b[g], o_c[g]}), e_vec);
        chk("busy", g, int'(o_busy[g]), int'(e_busy));
        chk("done", g, int'(o_done[g]), int'(e_done));
        chk("pass", g, int'(o_pass[g]), int'(e_pass));
        chk("err_count", g, int'(o_err[g]), e_err);
        chk("first_fail_valid", g, int'(o_ffv[g]), int'(e_ffv));
        if (e_ffv) chk("first_fail_vec", g, int'(o_ffvec[g]), e_ffvec);
        chk("fail_x", g, int'(o_fx[g]), int'(e_fx));
        chk("fail_y", g, int'(o_fy[g]), int'(e_fy));
        chk("state_idle", g, int'(o_dbg[g] != 2'd0), int'(e_busy));
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_busy == '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_idle", 0, int'(ok), 1);
    endtask

    // Pulses start, then records the relative edge of the first done of each instance.
    task automatic run_timed(input int repulse_at, output int d0, output int d1);
        d0 = -1;
        d1 = -1;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == repulse_at) start = 1'b1;
            if (k == repulse_at + 1) start = 1'b0;
            if (o_done[0] && d0 < 0) d0 = k;
            if (o_done[1] && d1 < 0) d1 = k;
        end
        start = 1'b0;
        wait_idle();
    endtask

    task automatic set_faults(input logic [7:0] nx, input logic [7:0] ny);
        @(posedge clk); #2;
        fx = nx;
        fy = ny;
    endtask

    task automatic check_cleared(input string tag);
        for (int g = 0; g < NI; g++) begin
            chk({tag, "_abc"}, g, int'({o_a[g], o_b[g], o_c[g]}), 0);
            chk({tag, "_busy"}, g, int'(o_busy[g]), 0);
            chk({tag, "_err"}, g, int'(o_err[g]), 0);
            chk({tag, "_flags"}, g, int'({o_pass[g], o_ffv[g], o_fx[g], o_fy[g], o_done[g]}), 0);
        end
    endtask

    task automatic stimulus();
        int d0, d1, d1b, k_rst;
        logic [7:0] rx, ry;
        repeat (3) @(posedge clk);
        #2;
        check_cleared("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Healthy unit: 8 vectors of 3 cycles, done on cycle 25 (edge 24 after accept).
        set_faults(8'h00, 8'h00);
        run_timed(-5, d0, d1);
        chk("s1_done_edge", 0, d0, 24);
        chk("s1_done_edge", 1, d1, 16);
        chk("s1_pass", 0, int'(o_pass[0]), 1);
        chk("s1_err", 0, int'(o_err[0]), 0);
        chk("s1_ffv", 0, int'(o_ffv[0]), 0);

        // y stuck at 0: only vectors 6 and 7 expect y=1.
        set_faults(8'h00, 8'b1100_0000);
        run_timed(-5, d0, d1);
        chk("s2_err", 0, int'(o_err[0]), 2);
        chk("s2_ffvec", 0, int'(o_ffvec[0]), 6);
        chk("s2_fail_xy", 0, int'({o_fx[0], o_fy[0]}), 1);
        chk("s2_pass", 0, int'(o_pass[0]), 0);

        // x inverted everywhere; the 2-bit counter saturates at 3.
        set_faults(8'hFF, 8'h00);
        run_timed(-5, d0, d1);
        chk("s3_err", 0, int'(o_err[0]), 8);
        chk("s3_ffvec", 0, int'(o_ffvec[0]), 0);
        chk("s3_fail_x", 0, int'(o_fx[0]), 1);
        chk("s3_err_sat", 1, int'(o_err[1]), 3);

        // start re-pulsed while vector 3 is on the bus is ignored.
        set_faults(8'h00, 8'h00);
        run_timed(9, d0, d1);
        chk("s4_done_edge", 0, d0, 24);
        chk("s4_pass", 0, int'(o_pass[0]), 1);
        chk("s4_err", 0, int'(o_err[0]), 0);

        // Asynchronous reset while instance 0 drives vector 4.
        set_faults(8'h10, 8'h00);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (13) @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check_cleared("s5_rst");
        @(posedge clk); #2 rst_n = 1'b1;
        run_timed(-5, d0, d1);
        chk("s5_err", 0, int'(o_err[0]), 1);
        chk("s5_ffvec", 0, int'(o_ffvec[0]), 4);
        chk("s5_fail_x", 0, int'(o_fx[0]), 1);

        // start held high: settle-1 instance restarts two edges after its done.
        set_faults(8'h21, 8'h80);
        @(posedge clk); #2 start = 1'b1;
        d0 = -1; d1 = -1; d1b = -1;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_done[0] && d0 < 0) d0 = k;
            if (o_done[1] && d1 < 0) d1 = k;
            else if (o_done[1] && d1 >= 0 && k > d1 && d1b < 0) d1b = k;
        end
        start = 1'b0;
        wait_idle();
        chk("s6_done_edge", 0, d0, 24);
        chk("s6_done_edge", 1, d1, 16);
        chk("s6_second_done_edge", 1, d1b, 34);

        // Random faults, random start lengths, stray mid-sweep starts and resets.
        for (int it = 0; it < 25; it++) begin
            rx = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            ry = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            set_faults(rx, ry);
            start = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #2 start = 1'b0;
            repeat ($urandom_range(1, 8)) @(posedge clk);
            #2 start = 1'b1;
            @(posedge clk); #2 start = 1'b0;
            if ($urandom_range(0, 4) == 0) begin
                k_rst = $urandom_range(0, 20);
                repeat (k_rst) @(posedge clk);
                #3 rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #2 rst_n = 1'b1;
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge clk);
                    for (int g = 0; g < NI; g++) compare_inst(g);
                    noise_x = 1'($urandom);
                    noise_y = 1'($urandom);
                end
            end
            begin
                stimulus();
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        join
    end
endmodule
